// File: rtl/id_stage_piped_pkg.sv
// Shared decode constants, control bundle type and condition evaluation for the ID stage.
package id_stage_piped_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_NUM_REGS   = 16;
  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned EXEC_CMD_W     = 4;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned STATUS_W       = 4;
  localparam int unsigned SHIFT_OP_W     = 12;
  localparam int unsigned SIGNED_IMM_W   = 24;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [EXEC_CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [EXEC_CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [EXEC_CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [EXEC_CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [EXEC_CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [EXEC_CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [EXEC_CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [EXEC_CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [EXEC_CMD_W-1:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic [EXEC_CMD_W-1:0] exec_cmd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_en;
    logic                  imm;
    logic                  branch;
    logic                  status_we;
  } ctrl_t;

  // True when the instruction should execute given the current flags; 1111 never does.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [STATUS_W-1:0] st);
    logic n, z, c, v;
    n = st[FLAG_N];
    z = st[FLAG_Z];
    c = st[FLAG_C];
    v = st[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_piped_if.sv
// IF->ID, writeback and ID/EX bus bundle; slave is the decode stage's view.
interface id_stage_piped_if
  import id_stage_piped_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_W-1:0]       pc_in;
  logic [INSTR_W-1:0]      instr_in;
  logic [STATUS_W-1:0]     status_in;
  logic                    hazard;
  logic                    flush;
  logic                    wb_en;
  logic [REG_ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]       wb_data;
  logic [REG_ADDR_W-1:0]   src1_out;
  logic [REG_ADDR_W-1:0]   src2_out;
  logic                    two_src_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W-1:0]       out_pc;
  logic [EXEC_CMD_W-1:0]   out_exec_cmd;
  logic                    out_mem_read;
  logic                    out_mem_write;
  logic                    out_wb_en;
  logic                    out_imm;
  logic                    out_branch;
  logic                    out_status_we;
  logic [DATA_W-1:0]       out_val_rn;
  logic [DATA_W-1:0]       out_val_rm;
  logic [REG_ADDR_W-1:0]   out_dest;
  logic [REG_ADDR_W-1:0]   out_src1;
  logic [REG_ADDR_W-1:0]   out_src2;
  logic [SHIFT_OP_W-1:0]   out_shift_operand;
  logic [SIGNED_IMM_W-1:0] out_signed_imm;

  modport slave (
    input  in_valid, pc_in, instr_in, status_in, hazard, flush,
           wb_en, wb_addr, wb_data, out_ready,
    output in_ready, src1_out, src2_out, two_src_out, out_valid, out_pc,
           out_exec_cmd, out_mem_read, out_mem_write, out_wb_en, out_imm,
           out_branch, out_status_we, out_val_rn, out_val_rm, out_dest,
           out_src1, out_src2, out_shift_operand, out_signed_imm
  );

  modport master (
    output in_valid, pc_in, instr_in, status_in, hazard, flush,
           wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, src1_out, src2_out, two_src_out, out_valid, out_pc,
           out_exec_cmd, out_mem_read, out_mem_write, out_wb_en, out_imm,
           out_branch, out_status_we, out_val_rn, out_val_rm, out_dest,
           out_src1, out_src2, out_shift_operand, out_signed_imm
  );
endinterface

// File: rtl/id_stage_piped_decode.sv
// Combinational instruction-class decode table: mode/opcode/S/I to control bundle.
module id_control_decode
  import id_stage_piped_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [3:0] opcode_i,
  input  logic       s_i,
  input  logic       imm_i,
  output ctrl_t      ctrl_c,
  output logic       str_c
);
  always_comb begin
    ctrl_c = '0;
    str_c  = 1'b0;
    case (mode_i)
      MODE_ALU: begin
        ctrl_c.imm       = imm_i;
        ctrl_c.wb_en     = 1'b1;
        ctrl_c.status_we = s_i;
        case (opcode_i)
          OP_MOV: ctrl_c.exec_cmd = CMD_MOV;
          OP_MVN: ctrl_c.exec_cmd = CMD_MVN;
          OP_ADD: ctrl_c.exec_cmd = CMD_ADD;
          OP_ADC: ctrl_c.exec_cmd = CMD_ADC;
          OP_SUB: ctrl_c.exec_cmd = CMD_SUB;
          OP_SBC: ctrl_c.exec_cmd = CMD_SBC;
          OP_AND: ctrl_c.exec_cmd = CMD_AND;
          OP_ORR: ctrl_c.exec_cmd = CMD_ORR;
          OP_EOR: ctrl_c.exec_cmd = CMD_EOR;
          OP_CMP: begin
            ctrl_c.exec_cmd  = CMD_SUB;
            ctrl_c.wb_en     = 1'b0;
            ctrl_c.status_we = 1'b1;
          end
          OP_TST: begin
            ctrl_c.exec_cmd  = CMD_AND;
            ctrl_c.wb_en     = 1'b0;
            ctrl_c.status_we = 1'b1;
          end
          default: ctrl_c = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl_c.exec_cmd  = CMD_ADD;
        ctrl_c.imm       = imm_i;
        ctrl_c.mem_read  = s_i;
        ctrl_c.wb_en     = s_i;
        ctrl_c.mem_write = ~s_i;
        str_c            = ~s_i;
      end
      MODE_BR: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.imm    = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end
endmodule

// File: rtl/id_stage_piped.sv
// Decode stage with inline register file and a stallable ID/EX slot.
// Optional ID_WB_BYPASS_EN: same-cycle writeback data is forwarded into register reads.
module id_stage_piped
  import id_stage_piped_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input logic            clk,
  input logic            rst,
  id_stage_piped_if.slave bus
);
  typedef struct packed {
    logic                    valid;
    ctrl_t                   ctrl;
    logic [ADDR_W-1:0]       pc;
    logic [DATA_W-1:0]       val_rn;
    logic [DATA_W-1:0]       val_rm;
    logic [REG_ADDR_W-1:0]   dest;
    logic [REG_ADDR_W-1:0]   src1;
    logic [REG_ADDR_W-1:0]   src2;
    logic [SHIFT_OP_W-1:0]   shift_op;
    logic [SIGNED_IMM_W-1:0] simm;
  } slot_t;

  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  slot_t                 slot_q, slot_d;
  ctrl_t                 dec_ctrl;
  logic                  dec_str;
  logic [REG_ADDR_W-1:0] src1, src2;
  logic [DATA_W-1:0]     rd_rn, rd_rm;
  logic                  advance;

  id_control_decode u_dec (
    .mode_i   (bus.instr_in[27:26]),
    .opcode_i (bus.instr_in[24:21]),
    .s_i      (bus.instr_in[20]),
    .imm_i    (bus.instr_in[25]),
    .ctrl_c   (dec_ctrl),
    .str_c    (dec_str)
  );

  assign src1 = bus.instr_in[16 +: REG_ADDR_W];
  assign src2 = dec_str ? bus.instr_in[12 +: REG_ADDR_W] : bus.instr_in[0 +: REG_ADDR_W];

  // Register file: async clear, write on posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (bus.wb_en) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rd_rn = regs_q[src1];
    rd_rm = regs_q[src2];
`ifdef ID_WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == src1)) rd_rn = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == src2)) rd_rm = bus.wb_data;
`endif
  end

  assign advance = bus.out_ready | ~slot_q.valid;

  // Slot priority: flush, stall-hold, load, bubble.
  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d.valid = 1'b0;
      slot_d.ctrl  = '0;
    end else if (advance) begin
      if (bus.in_valid && !bus.hazard) begin
        slot_d.valid    = 1'b1;
        slot_d.ctrl     = cond_pass(bus.instr_in[31:28], bus.status_in) ? dec_ctrl : '0;
        slot_d.pc       = bus.pc_in;
        slot_d.val_rn   = rd_rn;
        slot_d.val_rm   = rd_rm;
        slot_d.dest     = bus.instr_in[12 +: REG_ADDR_W];
        slot_d.src1     = src1;
        slot_d.src2     = src2;
        slot_d.shift_op = bus.instr_in[SHIFT_OP_W-1:0];
        slot_d.simm     = bus.instr_in[SIGNED_IMM_W-1:0];
      end else begin
        slot_d.valid = 1'b0;
        slot_d.ctrl  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign bus.in_ready          = advance & ~bus.hazard & ~bus.flush;
  assign bus.src1_out          = src1;
  assign bus.src2_out          = src2;
  assign bus.two_src_out       = ~bus.instr_in[25] | dec_str;
  assign bus.out_valid         = slot_q.valid;
  assign bus.out_pc            = slot_q.pc;
  assign bus.out_exec_cmd      = EXEC_CMD_W'(slot_q.ctrl.exec_cmd);
  assign bus.out_mem_read      = slot_q.ctrl.mem_read;
  assign bus.out_mem_write     = slot_q.ctrl.mem_write;
  assign bus.out_wb_en         = slot_q.ctrl.wb_en;
  assign bus.out_imm           = slot_q.ctrl.imm;
  assign bus.out_branch        = slot_q.ctrl.branch;
  assign bus.out_status_we     = slot_q.ctrl.status_we;
  assign bus.out_val_rn        = slot_q.val_rn;
  assign bus.out_val_rm        = slot_q.val_rm;
  assign bus.out_dest          = slot_q.dest;
  assign bus.out_src1          = slot_q.src1;
  assign bus.out_src2          = slot_q.src2;
  assign bus.out_shift_operand = slot_q.shift_op;
  assign bus.out_signed_imm    = slot_q.simm;
endmodule

// File: tb/tb_id_stage_piped.sv
// Directed bench for id_stage_piped: expected slot contents queued at issue, checked at load.
module tb_id_stage_piped;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_piped_if bus ();
  id_stage_piped dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cmd;
    logic [5:0]  ctl;   // {mem_read, mem_write, wb_en, imm, branch, status_we}
    logic [31:0] rn;
    logic [31:0] rm;
    logic [3:0]  src2;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc = 32'h100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and queue what the slot must hold after the next edge.
  task automatic issue(input logic [31:0] instr, input logic [3:0] cmd, input logic [5:0] ctl,
                       input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] src2);
    exp_t e;
    pc += 32'd4;
    bus.in_valid = 1'b1;
    bus.instr_in = instr;
    bus.pc_in    = pc;
    e.pc = pc; e.instr = instr; e.cmd = cmd; e.ctl = ctl; e.rn = rn; e.rm = rm; e.src2 = src2;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},    64'(bus.out_pc), 64'(e.pc));
      chk({tag, ".cmd"},   64'(bus.out_exec_cmd), 64'(e.cmd));
      chk({tag, ".ctl"},   64'({bus.out_mem_read, bus.out_mem_write, bus.out_wb_en,
                                bus.out_imm, bus.out_branch, bus.out_status_we}), 64'(e.ctl));
      chk({tag, ".rn"},    64'(bus.out_val_rn), 64'(e.rn));
      chk({tag, ".rm"},    64'(bus.out_val_rm), 64'(e.rm));
      chk({tag, ".dest"},  64'(bus.out_dest), 64'(e.instr[15:12]));
      chk({tag, ".src1"},  64'(bus.out_src1), 64'(e.instr[19:16]));
      chk({tag, ".src2"},  64'(bus.out_src2), 64'(e.src2));
      chk({tag, ".shop"},  64'(bus.out_shift_operand), 64'(e.instr[11:0]));
      chk({tag, ".simm"},  64'(bus.out_signed_imm), 64'(e.instr[23:0]));
    end
  endtask

  task automatic wb_write(input logic [3:0] addr, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
    step();
    bus.wb_en = 1'b0;
  endtask

  initial begin
    logic [31:0] byp_rm;
`ifdef ID_WB_BYPASS_EN
    byp_rm = 32'hDEAD;
`else
    byp_rm = 32'h1111;
`endif
    rst = 1'b1;
    bus.in_valid = 0; bus.pc_in = '0; bus.instr_in = '0; bus.status_in = '0;
    bus.hazard = 0; bus.flush = 0; bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.pc", 64'(bus.out_pc), 64'd0);
    chk("rst.ctl", 64'({bus.out_exec_cmd, bus.out_wb_en, bus.out_mem_read}), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);

    wb_write(4'd2, 32'd5);
    wb_write(4'd3, 32'd7);

    // ADD r1,r2,r3
    issue(32'hE0821003, 4'b0010, 6'b001000, 32'd5, 32'd7, 4'd3);
    #1;
    chk("add.src1_out", 64'(bus.src1_out), 64'd2);
    chk("add.src2_out", 64'(bus.src2_out), 64'd3);
    chk("add.two_src", 64'(bus.two_src_out), 64'd1);
    step();
    check_out("add");

    // Hazard for two cycles, then SUB r5,r2,r3 issues
    bus.instr_in = 32'hE0425003;
    bus.hazard = 1'b1;
    #1 chk("haz.in_ready0", 64'(bus.in_ready), 64'd0);
    step();
    chk("haz.valid0", 64'(bus.out_valid), 64'd0);
    chk("haz.in_ready1", 64'(bus.in_ready), 64'd0);
    step();
    chk("haz.valid1", 64'(bus.out_valid), 64'd0);
    bus.hazard = 1'b0;
    issue(32'hE0425003, 4'b0100, 6'b001000, 32'd5, 32'd7, 4'd3);
    #1 chk("haz.in_ready2", 64'(bus.in_ready), 64'd1);
    step();
    check_out("sub");

    // Downstream stall with ORR r7,r2,r3 waiting
    bus.out_ready = 1'b0;
    bus.instr_in = 32'hE1827003;
    #1 chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("stall.valid", 64'(bus.out_valid), 64'd1);
    chk("stall.cmd_hold", 64'(bus.out_exec_cmd), 64'd4);
    chk("stall.dest_hold", 64'(bus.out_dest), 64'd5);
    chk("stall.in_ready2", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    issue(32'hE1827003, 4'b0111, 6'b001000, 32'd5, 32'd7, 4'd3);
    #1 chk("stall.release", 64'(bus.in_ready), 64'd1);
    step();
    check_out("orr");

    // ADDEQ: squashed with Z=0, executes with Z=1
    bus.status_in = 4'b0000;
    issue(32'h00821003, 4'b0000, 6'b000000, 32'd5, 32'd7, 4'd3);
    step();
    check_out("addeq_fail");
    bus.status_in = 4'b0100;
    issue(32'h00821003, 4'b0010, 6'b001000, 32'd5, 32'd7, 4'd3);
    step();
    check_out("addeq_pass");

    // Flush while stalled and a new instruction is offered
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    #1 chk("flush.in_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("flush.valid", 64'(bus.out_valid), 64'd0);
    chk("flush.ctl", 64'({bus.out_exec_cmd, bus.out_wb_en}), 64'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.status_in = 4'b0000;
    step();

    // LDR r1,[r2] / STR r1,[r2] / B / CMP r2,#5 / never-condition
    issue(32'hE5921000, 4'b0010, 6'b101000, 32'd5, 32'd0, 4'd0);
    step();
    check_out("ldr");
    issue(32'hE5821000, 4'b0010, 6'b010000, 32'd5, 32'd0, 4'd1);
    #1 chk("str.src2_out", 64'(bus.src2_out), 64'd1);
    chk("str.two_src", 64'(bus.two_src_out), 64'd1);
    step();
    check_out("str");
    issue(32'hEA000010, 4'b0000, 6'b000110, 32'd0, 32'd0, 4'd0);
    step();
    check_out("branch");
    issue(32'hE3520005, 4'b0100, 6'b000101, 32'd5, 32'd0, 4'd5);
    #1 chk("cmp.two_src", 64'(bus.two_src_out), 64'd0);
    step();
    check_out("cmp");
    issue(32'hF0821003, 4'b0000, 6'b000000, 32'd5, 32'd7, 4'd3);
    step();
    check_out("never");

    // Same-cycle writeback to r4 while MOV r0,r4 reads it
    bus.in_valid = 1'b0;
    wb_write(4'd4, 32'h1111);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 32'hDEAD;
    issue(32'hE1A20004, 4'b0001, 6'b001000, 32'd5, byp_rm, 4'd4);
    step();
    bus.wb_en = 1'b0;
    check_out("bypass");
    issue(32'hE1A20004, 4'b0001, 6'b001000, 32'd5, 32'hDEAD, 4'd4);
    step();
    check_out("after_wb");

    // Reset during a stall clears the slot and the register file
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid.valid", 64'(bus.out_valid), 64'd0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    issue(32'hE1A00002, 4'b0001, 6'b001000, 32'd0, 32'd0, 4'd2);
    step();
    check_out("post_rst");
    bus.in_valid = 1'b0;
    step();
    chk("sb.empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage_piped.md
Name: id_stage_piped

Overview:
- Parametrised decode stage with integrated register file and a registered ID/EX pipeline slot.
- Uses a valid/ready handshake, hazard bubble insertion, branch flush and condition-fail squash.
- Sits between IF stage (upstream) and EXE stage (downstream).
- Replaces the combinational decode path, so EXE now sees registered, stallable control.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 32, PC width
- NUM_REGS, 16, architectural registers (power of two)
- REG_ADDR_W, 4, log2(NUM_REGS)
- EXEC_CMD_W, 4, execute command width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  IF holds a valid instruction
- in_ready  out  1  ID accepts instruction this cycle
- pc_in  in  ADDR_W  PC of instruction
- instr_in  in  32  instruction word
- status_in  in  4  flags {N,Z,C,V}
- hazard  in  1  hazard unit: current instruction must stall
- flush  in  1  branch taken in EXE; kill ID/EX slot
- wb_en  in  1  register write enable
- wb_addr  in  REG_ADDR_W  write address
- wb_data  in  DATA_W  write data
- src1_out, src2_out  out  REG_ADDR_W  combinational source addresses (to hazard unit)
- two_src_out  out  1  combinational; instruction reads src2
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EXE consumes slot
- out_pc  out  ADDR_W  registered PC
- out_exec_cmd  out  EXEC_CMD_W  registered ALU command
- out_mem_read, out_mem_write, out_wb_en, out_imm, out_branch, out_status_we  out  1 each  registered controls
- out_val_rn, out_val_rm  out  DATA_W  registered operand values
- out_dest  out  REG_ADDR_W  registered instr[15:12]
- out_src1, out_src2  out  REG_ADDR_W  registered source addresses (for forwarding)
- out_shift_operand  out  12  registered instr[11:0]
- out_signed_imm  out  24  registered instr[23:0]

Behaviour:
- Decode: mode = instr[27:26], opcode = instr[24:21], S = instr[20], I = instr[25].
  - Mode 00 opcodes map to exec_cmd: MOV→0001, MVN→1001, ADD→0010, ADC→0011, SUB→0100, SBC→0101, AND→0110, ORR→0111, EOR→1000.
  - CMP→0100 and TST→0110, both with wb_en = 0 and status_we = 1.
  - Otherwise status_we = S.
  - Mode 01: exec_cmd 0010; S = 1 is LDR (mem_read, wb_en); S = 0 is STR (mem_write).
  - Mode 10: branch = 1, imm = 1.
  - Any undefined encoding yields all controls 0.
- src1 = instr[19:16]; src2 = instr[15:12] if STR, else instr[3:0]. two_src = ~I | STR.
- Condition check: 4-bit cond instr[31:28] against status_in, standard EQ..AL encoding; 1111 = never.
- Register file: NUM_REGS × DATA_W. All entries reset to 0 asynchronously; written at posedge when wb_en. Reads are combinational.
- advance = out_ready | ~out_valid. in_ready = advance & ~hazard & ~flush.
- On each posedge, priority order:
  1. rst: out_valid = 0, all registered outputs = 0.
  2. flush: out_valid = 0, controls = 0 (applies even when !advance).
  3. !advance: hold every output register.
  4. in_valid & ~hazard: load slot, out_valid = 1. If the condition fails, load all control bits as 0 (NOP squash); data fields are still loaded.
  5. Else: bubble, out_valid = 0, controls = 0.
- Latency: one cycle, instruction to ID/EX slot. Throughput: one per cycle when out_ready is held high.
- Simultaneous hazard and flush: flush wins; nothing accepted.
- Simultaneous wb_en and a read of the same address: see Optional Feature.
- Reset mid-stall clears the slot; register contents are lost (reset to 0).

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: a read of an address equal to wb_addr while wb_en = 1 returns wb_data in the same cycle, and that value is captured into out_val_rn/out_val_rm.
- Undefined: the read returns the pre-write value, and the hazard unit must cover the WB→ID distance.
- A write to an address does not affect reads of any other address in either mode.

Decomposition:
- Shared package holds: exec_cmd localparams, mode encodings, cond codes, flag bit indices, and widths for shift operand (12) and signed immediate (24).
- One sub-module: id_control_decode, the combinational decode table, reused by the verification model.
- Register file stays inline.

Test Plan:
- Reset, then ADD r1,r2,r3 (0xE0821003) with r2 = 5, r3 = 7, out_ready = 1 → next cycle out_valid = 1, exec_cmd = 0010, wb_en = 1, val_rn = 5, val_rm = 7, dest = 1.
- hazard = 1 for 2 cycles with in_valid = 1 → in_ready = 0 and out_valid = 0 for both cycles; the instruction issues on the third cycle.
- out_ready = 0 while the slot is full, with a new instruction presented → slot holds its value and in_ready = 0; both advance one cycle after out_ready = 1.
- ADDEQ with status_in Z = 0 → out_valid = 1 and all controls 0. Same instruction with Z = 1 → wb_en = 1.
- flush = 1 together with in_valid = 1 and out_ready = 0 → out_valid = 0 next cycle and in_ready = 0.
- Write 0xDEAD to r4 with wb_en = 1 while decoding MOV r0,r4 → with ID_WB_BYPASS_EN, val_rm = 0xDEAD; without it, val_rm = the old value.
